// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the x^6+x^5+1 sequence checker and its generator.
// Holds the checker state encoding, LFSR width, sequence period and taps.
package lfsr_checker_pkg;

  localparam int unsigned LFSR_W     = 6;
  localparam int unsigned SEQ_PERIOD = 63;
  localparam int unsigned TAP_HI     = 5;
  localparam int unsigned TAP_LO     = 4;
  localparam int unsigned WIN_W      = 6;
  localparam int unsigned FILL_W     = 3;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/lfsr_checker_predict.sv
// Next-bit predictor for the x^6+x^5+1 sequence; shared with the generator.
// Ports: hist  - 6-bit history, newest bit in hist[0]
//        pred_c - predicted next bit (combinational)
module lfsr_predict
  import lfsr_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] hist,
  output logic              pred_c
);

  assign pred_c = hist[TAP_HI] ^ hist[TAP_LO];

endmodule

// File: rtl/lfsr_checker.sv
// Serial checker for the 6-bit PRNG stream: seeds from the input, verifies
// LOCK_COUNT predictions, then flywheels on its own predictions while locked.
// Ports: clk, rst (async active-low), din/din_valid (serial input),
//        clr_cnt (sync clear of err_count), locked, err_pulse, err_count.
module lfsr_checker
  import lfsr_checker_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = 12,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MATCH_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT + 1)  : 1;
  localparam int unsigned WERR_W  = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH + 1) : 1;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   h_q, h_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [WERR_W-1:0]   werr_q, werr_d;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic                pred_c;
  logic                err_hit_c;
  logic [LFSR_W-1:0]   h_shift_c;
  logic [MATCH_W-1:0]  match_inc_c;
  logic [WERR_W-1:0]   werr_base_c;
  logic [WERR_W-1:0]   werr_inc_c;

  lfsr_predict u_predict (
    .hist   (h_q),
    .pred_c (pred_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SEED;
      h_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state and counter logic; everything holds when din_valid is low
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_hit_c   = 1'b0;
    h_shift_c   = {h_q[LFSR_W-2:0], din};
    match_inc_c = match_q + MATCH_W'(1);
    werr_base_c = werr_q;
    werr_inc_c  = werr_q + WERR_W'(1);

    unique case (state_q)
      ST_SEED: begin
        if (din_valid) begin
          h_d = h_shift_c;
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            // An all-zero history would predict zeros forever; refill instead
            fill_d = '0;
            if (h_shift_c != '0) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
      end

      ST_VERIFY: begin
        if (din_valid) begin
          h_d = h_shift_c;
          if (din == pred_c) begin
            if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
              state_d = ST_LOCKED;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_inc_c;
            end
          end else begin
            state_d = ST_SEED;
            fill_d  = '0;
            match_d = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (din_valid) begin
          // Flywheel on the prediction so a corrupt bit is not fed back
          h_d = {h_q[LFSR_W-2:0], pred_c};
          if (win_q == WIN_W'(SEQ_PERIOD - 1)) begin
            win_d       = '0;
            werr_base_c = '0;
          end else begin
            win_d = win_q + WIN_W'(1);
          end
          werr_inc_c = werr_base_c + WERR_W'(1);
          werr_d     = werr_base_c;
          if (din != pred_c) begin
            err_hit_c = 1'b1;
            if (werr_inc_c == WERR_W'(LOSS_THRESH)) begin
              state_d = ST_SEED;
              fill_d  = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              werr_d = werr_inc_c;
            end
          end
        end
      end

      default: begin
        state_d = ST_SEED;
        fill_d  = '0;
        match_d = '0;
      end
    endcase

    locked_d    = (state_d == ST_LOCKED);
    err_pulse_d = err_hit_c;

    // Clear wins over the old value but not over an error on the same cycle
    if (clr_cnt) begin
      err_cnt_d = err_hit_c ? CNT_W'(1) : '0;
    end else if (err_hit_c && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: stimulus pushes expected outputs for
// the next clock, a monitor on the falling edge pops and compares them.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;

  int cyc    = 0;
  int checks = 0;
  int passed = 0;

  logic [5:0] gen;

  typedef struct {
    int          cyc;
    string       name;
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;

  lfsr_checker #(.LOCK_COUNT(12), .LOSS_THRESH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due on this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        $display("FAIL %s: check due at cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if ({locked, err_pulse, err_count} !== {e.lk, e.pl, e.cnt}) begin
        $display("FAIL %s @%0d: got locked=%b err_pulse=%b err_count=%0d, expected locked=%b err_pulse=%b err_count=%0d",
                 e.name, cyc, locked, err_pulse, err_count, e.lk, e.pl, e.cnt);
      end else begin
        passed++;
      end
    end
  end

  function automatic logic gen_bit();
    logic n;
    n   = gen[5] ^ gen[4];
    gen = {gen[4:0], n};
    return n;
  endfunction

  // Next six generator outputs, first output in bit 5
  function automatic logic [5:0] peek6(input logic [5:0] g);
    logic [5:0] t;
    t = g;
    for (int i = 0; i < 6; i++) t = {t[4:0], t[5] ^ t[4]};
    return t;
  endfunction

  task automatic drive(input logic d, input logic v, input logic c, input logic r);
    @(negedge clk);
    din       = d;
    din_valid = v;
    clr_cnt   = c;
    rst       = r;
  endtask

  task automatic expect_next(input string name, input logic lk, input logic pl,
                             input logic [15:0] cnt);
    exp_t x;
    x.cyc  = cyc + 1;
    x.name = name;
    x.lk   = lk;
    x.pl   = pl;
    x.cnt  = cnt;
    q.push_back(x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic       flip;
    int         errs;
    int         nv;

    rst = 1'b0; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    gen = 6'b000001;
    repeat (3) @(negedge clk);

    // Reset holds everything at zero even with activity on the inputs
    drive(1'b1, 1'b1, 1'b1, 1'b0); expect_next("reset_state", 1'b0, 1'b0, 16'd0);

    // Clean PRNG stream: lock after exactly 6+12 valid bits
    for (int k = 1; k <= 18; k++) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      expect_next("t1_lock_edge", (k == 18), 1'b0, 16'd0);
    end
    for (int i = 0; i < 159 * 63; i++) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      if (i % 2000 == 1999 || i == 159 * 63 - 1)
        expect_next("t1_long_run", 1'b1, 1'b0, 16'd0);
    end

    // One corrupted bit inside a window: single pulse, count 1, still locked
    for (int i = 0; i < 63; i++) begin
      flip = (i == 10);
      drive(gen_bit() ^ flip, 1'b1, 1'b0, 1'b1);
      if (i == 10) expect_next("t2_single_err", 1'b1, 1'b1, 16'd1);
      if (i == 11) expect_next("t2_pulse_width", 1'b1, 1'b0, 16'd1);
      if (i == 62) expect_next("t2_window_end", 1'b1, 1'b0, 16'd1);
    end

    // clr_cnt on an idle cycle clears the counter and keeps lock
    drive(1'b0, 1'b0, 1'b1, 1'b1); expect_next("t3_clear", 1'b1, 1'b0, 16'd0);

    // Four errors within one window: loss on the 4th, relock 18 bits later
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      flip = (i == 0 || i == 3 || i == 6 || i == 9);
      if (flip) errs++;
      drive(gen_bit() ^ flip, 1'b1, 1'b0, 1'b1);
      expect_next("t3_loss_relock", (i < 9) || (i >= 27), flip, 16'(errs));
    end
    // Advance to the start of the next window (relocked samples 0,1 done)
    for (int i = 2; i < 63; i++) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      expect_next("t3_align", 1'b1, 1'b0, 16'd4);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1); expect_next("t4_clear", 1'b1, 1'b0, 16'd0);

    // Error on the wrap sample counts into the new window
    errs = 0;
    for (int j = 0; j < 67; j++) begin
      flip = (j == 59 || j == 60 || j == 61 || j == 62 || j == 64 || j == 65 || j == 66);
      if (flip) errs++;
      drive(gen_bit() ^ flip, 1'b1, 1'b0, 1'b1);
      expect_next("t4_window_wrap", (j < 66), flip, 16'(errs));
    end

    // Constant zero input never leaves SEED
    drive(1'b0, 1'b0, 1'b0, 1'b0); expect_next("t5_reset", 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 500; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      if (i % 100 == 99) expect_next("t5_all_zero", 1'b0, 1'b0, 16'd0);
    end

    // Qualified stream with din_valid toggling; invalid cycles carry junk
    drive(1'b0, 1'b0, 1'b0, 1'b0); expect_next("t6_reset", 1'b0, 1'b0, 16'd0);
    gen = 6'b000001;
    nv  = 0;
    for (int i = 0; i < 36; i++) begin
      if (i % 2 == 0) begin
        nv++;
        drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      end else begin
        drive(1'b1, 1'b0, 1'b0, 1'b1);
      end
      expect_next("t6_gapped_lock", (nv >= 18), 1'b0, 16'd0);
    end

    // Mid-lock reset, then release with clr_cnt and a corrupt bit
    for (int i = 0; i < 5; i++) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      expect_next("t7_locked", 1'b1, 1'b0, 16'd0);
    end
    drive(~gen_bit(), 1'b1, 1'b0, 1'b1); expect_next("t7_pre_err", 1'b1, 1'b1, 16'd1);
    drive(gen_bit(), 1'b1, 1'b0, 1'b0);  expect_next("t7_in_reset", 1'b0, 1'b0, 16'd0);
    // Keep the corrupted release bit from producing an all-zero seed
    while (peek6(gen) == 6'b100000) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b0); expect_next("t7_in_reset", 1'b0, 1'b0, 16'd0);
    end
    drive(~gen_bit(), 1'b1, 1'b1, 1'b1); expect_next("t7_release", 1'b0, 1'b0, 16'd0);
    // Bad seed fails first verify (bit 7); refill 8..13, verify 14..25
    for (int k = 2; k <= 25; k++) begin
      drive(gen_bit(), 1'b1, 1'b0, 1'b1);
      expect_next("t7_relock", (k == 25), 1'b0, 16'd0);
    end
    drive(gen_bit(), 1'b1, 1'b0, 1'b1); expect_next("t7_final", 1'b1, 1'b0, 16'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
